// File: rtl/controle_pkg.sv
// Shared definitions for the multi-cycle control block: opcodes, ALU codes, states, control bundle.
// Latency: none (types and a pure decode function only).
// Backpressure: not applicable.
package controle_pkg;

   // Opcodes after reduction to 3 bits. Any opcode with nonzero upper bits is mapped to OP_HALT.
   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_MUL   = 3'b011;
   localparam logic [2:0] OP_CLEAR = 3'b100;
   localparam logic [2:0] OP_HALT  = 3'b101;
   localparam logic [2:0] OP_READ  = 3'b110;
   localparam logic [2:0] OP_WRITE = 3'b111;

   // One-hot ALU operation selects.
   localparam logic [3:0] ALU_ADD = 4'b1000;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_MUL = 4'b0010;
   localparam logic [3:0] ALU_DIV = 4'b0001;

   typedef enum logic [2:0] {
      IDLE,
      ALU,
      START,
      WAIT_ALU,
      MEM,
      CLEAR,
      HALT
   } state_t;

   // Moore part of the outputs. RegEsc is absent because it depends on the current-cycle acks.
   typedef struct packed {
      logic       instr_ready;
      logic [3:0] alu_code;
      logic       alu_start;
      logic       memtoreg;
      logic       memen;
      logic       memop;
      logic       fonte;
      logic       stop;
      logic       clear;
   } ctl_t;

   // Moore decode of a state plus the latched opcode.
   function automatic ctl_t decode(input state_t s, input logic [2:0] op);
      ctl_t c;
      c = '0;
      case (s)
         IDLE:  c.instr_ready = 1'b1;
         ALU:   c.alu_code    = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
         START: begin
            c.alu_code  = (op == OP_DIV) ? ALU_DIV : ALU_MUL;
            c.alu_start = 1'b1;
         end
         WAIT_ALU: c.alu_code = (op == OP_DIV) ? ALU_DIV : ALU_MUL;
         MEM: begin
            c.memen    = 1'b1;
            c.memop    = (op == OP_WRITE);
            c.memtoreg = (op == OP_READ);
            c.fonte    = (op == OP_READ);
         end
         CLEAR: begin
            c.memen = 1'b1;
            c.clear = 1'b1;
         end
         HALT:    c.stop = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/controle_clear_cnt.sv
// Address counter for the memory clear sweep, with terminal-count flag at MEM_DEPTH-1.
// Latency: address advances one edge after an accepted ack; last is combinational from the count.
// Backpressure: advances only on inc; clr restarts the sweep at 0.
module controle_clear_cnt #(
   parameter int MEM_DEPTH = 16,
   parameter int ADDR_W    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc,
   input  logic              clr,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   assign last = (addr == ADDR_W'(MEM_DEPTH - 1));

   // Count acks; the terminal ack returns to 0 so the sweep never runs past the last word.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         addr <= '0;
      end else if (inc) begin
         addr <= last ? '0 : addr + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle control sequencer: one instruction per handshake, waits on ALU done / memory ack.
// Latency: ALU ops 1 cycle, mul/div 2+ cycles, memory ops until MemAck, clear MEM_DEPTH acks.
// Backpressure: InstrReady only in IDLE; optional CONTROLE_MEM_TIMEOUT_EN adds a memory ack timeout.
module controle_multiciclo
   import controle_pkg::*;
#(
   parameter int OPCODE_W       = 3,
   parameter int ALU_W          = 4,
   parameter int MEM_DEPTH      = 16,
   parameter int ADDR_W         = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                Clock,
   input  logic                Reset_n,
   input  logic                InstrValid,
   output logic                InstrReady,
   input  logic [OPCODE_W-1:0] OpCode,
   input  logic                AluDone,
   input  logic                MemAck,
   input  logic                Resume,
   output logic [ALU_W-1:0]    ALUCode,
   output logic                AluStart,
   output logic                MemtoReg,
   output logic                MemEn,
   output logic                MemOp,
   output logic                FonteEscrita,
   output logic                RegEsc,
   output logic                Stop,
   output logic                Clear,
   output logic [ADDR_W-1:0]   ClearAddr,
   output logic                Busy,
   output logic                MemErr
);

   state_t            state;
   state_t            nxt_state;
   logic [2:0]        op_q;
   logic [2:0]        nxt_op;
   logic [2:0]        op_in;
   logic              upper_nz;
   logic              hs;
   logic              tmo_hit;
   logic              clr_last;
   logic [ADDR_W-1:0] clr_addr;
   ctl_t              ctl_q;

   if (TIMEOUT_CYCLES < 1 || MEM_DEPTH < 1 || (2 ** ADDR_W) < MEM_DEPTH) begin : g_bad_params
      $error("controle_multiciclo: invalid TIMEOUT_CYCLES / MEM_DEPTH / ADDR_W");
   end

   // Opcodes wider than 3 bits with any upper bit set behave as halt.
   if (OPCODE_W > 3) begin : g_upper
      assign upper_nz = |OpCode[OPCODE_W-1:3];
   end else begin : g_no_upper
      assign upper_nz = 1'b0;
   end

   assign op_in = upper_nz ? OP_HALT : OpCode[2:0];
   assign hs    = InstrValid && (state == IDLE);

   // Next-state selection; acks outside their wait states fall through untouched.
   always_comb begin
      nxt_state = state;
      nxt_op    = op_q;
      case (state)
         IDLE: begin
            if (InstrValid) begin
               nxt_op = op_in;
               case (op_in)
                  OP_ADD, OP_SUB:   nxt_state = ALU;
                  OP_MUL, OP_DIV:   nxt_state = START;
                  OP_READ, OP_WRITE: nxt_state = MEM;
                  OP_CLEAR:         nxt_state = CLEAR;
                  default:          nxt_state = HALT;
               endcase
            end
         end
         ALU:      nxt_state = IDLE;
         START:    nxt_state = WAIT_ALU;
         WAIT_ALU: if (AluDone) nxt_state = IDLE;
         MEM: begin
            if (MemAck)       nxt_state = IDLE;
            else if (tmo_hit) nxt_state = HALT;
         end
         CLEAR: begin
            if (MemAck && clr_last) nxt_state = IDLE;
            else if (tmo_hit)       nxt_state = HALT;
         end
         HALT:    if (Resume) nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   // State, latched opcode and the registered Moore output bundle; reset aborts any operation.
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state <= IDLE;
         op_q  <= OP_ADD;
         ctl_q <= decode(IDLE, OP_ADD);
      end else begin
         state <= nxt_state;
         op_q  <= nxt_op;
         ctl_q <= decode(nxt_state, nxt_op);
      end
   end

   controle_clear_cnt #(
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_W    (ADDR_W)
   ) u_clear_cnt (
      .clk   (Clock),
      .rst_n (Reset_n),
      .inc   ((state == CLEAR) && MemAck),
      .clr   (hs),
      .addr  (clr_addr),
      .last  (clr_last)
   );

`ifdef CONTROLE_MEM_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt;
   logic             in_mem;

   assign in_mem  = (state == MEM) || (state == CLEAR);
   assign tmo_hit = in_mem && !MemAck && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
   assign MemErr  = Reset_n && tmo_hit;

   // Cycles spent waiting for an ack; any ack, leaving the memory states or a timeout restarts it.
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         tmo_cnt <= '0;
      end else if (!in_mem || MemAck || tmo_hit) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign MemErr  = 1'b0;
`endif

   // Everything is forced low while reset is asserted, including InstrReady.
   assign InstrReady   = Reset_n && ctl_q.instr_ready;
   assign ALUCode      = Reset_n ? ALU_W'(ctl_q.alu_code) : '0;
   assign AluStart     = Reset_n && ctl_q.alu_start;
   assign MemtoReg     = Reset_n && ctl_q.memtoreg;
   assign MemEn        = Reset_n && ctl_q.memen;
   assign MemOp        = Reset_n && ctl_q.memop;
   assign FonteEscrita = Reset_n && ctl_q.fonte;
   assign Stop         = Reset_n && ctl_q.stop;
   assign Clear        = Reset_n && ctl_q.clear;
   assign ClearAddr    = Reset_n ? clr_addr : '0;
   assign Busy         = Reset_n && (state != IDLE);
   assign RegEsc       = Reset_n && ((state == ALU) ||
                                     ((state == WAIT_ALU) && AluDone) ||
                                     ((state == MEM) && (op_q == OP_READ) && MemAck));

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: cycle-by-cycle vector table plus hand-written sequences.
// Latency: inputs applied 1 time unit after the rising edge, outputs sampled 2 units later.
// Backpressure: exercised through InstrValid held while InstrReady is low.
module tb_controle_multiciclo;

   logic       Clock = 1'b0;
   logic       Reset_n, InstrValid, AluDone, MemAck, Resume;
   logic [2:0] OpCode;

   logic       InstrReady, AluStart, MemtoReg, MemEn, MemOp, FonteEscrita;
   logic       RegEsc, Stop, Clear, Busy, MemErr;
   logic [3:0] ALUCode, ClearAddr;

   logic       d1_InstrReady, d1_AluStart, d1_MemtoReg, d1_MemEn, d1_MemOp, d1_FonteEscrita;
   logic       d1_RegEsc, d1_Stop, d1_Clear, d1_Busy, d1_MemErr;
   logic [3:0] d1_ALUCode, d1_ClearAddr;

   always #5 Clock = ~Clock;

   controle_multiciclo #(
      .OPCODE_W(3), .ALU_W(4), .MEM_DEPTH(4), .ADDR_W(4), .TIMEOUT_CYCLES(8)
   ) dut (
      .Clock(Clock), .Reset_n(Reset_n), .InstrValid(InstrValid), .InstrReady(InstrReady),
      .OpCode(OpCode), .AluDone(AluDone), .MemAck(MemAck), .Resume(Resume),
      .ALUCode(ALUCode), .AluStart(AluStart), .MemtoReg(MemtoReg), .MemEn(MemEn),
      .MemOp(MemOp), .FonteEscrita(FonteEscrita), .RegEsc(RegEsc), .Stop(Stop),
      .Clear(Clear), .ClearAddr(ClearAddr), .Busy(Busy), .MemErr(MemErr)
   );

   controle_multiciclo #(
      .OPCODE_W(3), .ALU_W(4), .MEM_DEPTH(1), .ADDR_W(4), .TIMEOUT_CYCLES(8)
   ) dut1 (
      .Clock(Clock), .Reset_n(Reset_n), .InstrValid(InstrValid), .InstrReady(d1_InstrReady),
      .OpCode(OpCode), .AluDone(AluDone), .MemAck(MemAck), .Resume(Resume),
      .ALUCode(d1_ALUCode), .AluStart(d1_AluStart), .MemtoReg(d1_MemtoReg), .MemEn(d1_MemEn),
      .MemOp(d1_MemOp), .FonteEscrita(d1_FonteEscrita), .RegEsc(d1_RegEsc), .Stop(d1_Stop),
      .Clear(d1_Clear), .ClearAddr(d1_ClearAddr), .Busy(d1_Busy), .MemErr(d1_MemErr)
   );

   // Inputs: {Reset_n, InstrValid, OpCode[2:0], AluDone, MemAck, Resume}
   // Outputs: {InstrReady, ALUCode[3:0], AluStart, MemtoReg, MemEn, MemOp, FonteEscrita,
   //           RegEsc, Stop, Clear, ClearAddr[3:0], Busy, MemErr}
   typedef struct {
      logic [7:0]  in;
      logic [18:0] exp;
   } vec_t;

   localparam logic [18:0] E_RST  = 19'b0_0000_0_0_0_0_0_0_0_0_0000_0_0;
   localparam logic [18:0] E_IDLE = 19'b1_0000_0_0_0_0_0_0_0_0_0000_0_0;
   localparam logic [18:0] E_ADD  = 19'b0_1000_0_0_0_0_0_1_0_0_0000_1_0;
   localparam logic [18:0] E_SUB  = 19'b0_0100_0_0_0_0_0_1_0_0_0000_1_0;
   localparam logic [18:0] E_MULS = 19'b0_0010_1_0_0_0_0_0_0_0_0000_1_0;
   localparam logic [18:0] E_MULW = 19'b0_0010_0_0_0_0_0_0_0_0_0000_1_0;
   localparam logic [18:0] E_MULD = 19'b0_0010_0_0_0_0_0_1_0_0_0000_1_0;
   localparam logic [18:0] E_DIVS = 19'b0_0001_1_0_0_0_0_0_0_0_0000_1_0;
   localparam logic [18:0] E_DIVD = 19'b0_0001_0_0_0_0_0_1_0_0_0000_1_0;
   localparam logic [18:0] E_RD   = 19'b0_0000_0_1_1_0_1_0_0_0_0000_1_0;
   localparam logic [18:0] E_RDA  = 19'b0_0000_0_1_1_0_1_1_0_0_0000_1_0;
   localparam logic [18:0] E_WR   = 19'b0_0000_0_0_1_1_0_0_0_0_0000_1_0;
   localparam logic [18:0] E_HALT = 19'b0_0000_0_0_0_0_0_0_1_0_0000_1_0;

   localparam logic [7:0] I_NOP = 8'b1_0_000_0_0_0;

   int nvec = 0;
   int nerr = 0;

   function automatic logic [18:0] eclr(input logic [3:0] ca);
      return {1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ca, 1'b1, 1'b0};
   endfunction

   function automatic logic [18:0] outs();
      return {InstrReady, ALUCode, AluStart, MemtoReg, MemEn, MemOp, FonteEscrita,
              RegEsc, Stop, Clear, ClearAddr, Busy, MemErr};
   endfunction

   task automatic apply(input logic [7:0] in);
      {Reset_n, InstrValid, OpCode, AluDone, MemAck, Resume} = in;
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string nm, input logic [18:0] got, input logic [18:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %b required %b", nm, got, exp);
      end
   endtask

   initial begin
      vec_t tbl[$];

      // reset with InstrValid held high, then release
      tbl.push_back('{8'b0_1_000_0_0_0, E_RST});
      tbl.push_back('{8'b0_1_000_0_0_0, E_RST});
      tbl.push_back('{I_NOP,            E_IDLE});
      // add accepted, then sub offered back-to-back
      tbl.push_back('{8'b1_1_000_0_0_0, E_IDLE});
      tbl.push_back('{8'b1_1_001_0_0_0, E_ADD});
      tbl.push_back('{8'b1_1_001_0_0_0, E_IDLE});
      tbl.push_back('{I_NOP,            E_SUB});
      tbl.push_back('{I_NOP,            E_IDLE});
      // mul with AluDone forced in START, done on the 5th cycle after START
      tbl.push_back('{8'b1_1_011_0_0_0, E_IDLE});
      tbl.push_back('{8'b1_0_000_1_0_0, E_MULS});
      for (int i = 0; i < 4; i++) tbl.push_back('{I_NOP, E_MULW});
      tbl.push_back('{8'b1_0_000_1_0_0, E_MULD});
      tbl.push_back('{8'b1_0_000_1_1_0, E_IDLE});
      // div with immediate done
      tbl.push_back('{8'b1_1_010_0_0_0, E_IDLE});
      tbl.push_back('{I_NOP,            E_DIVS});
      tbl.push_back('{8'b1_0_000_1_0_0, E_DIVD});
      tbl.push_back('{I_NOP,            E_IDLE});
      // read: spurious AluDone, then ack
      tbl.push_back('{8'b1_1_110_0_0_0, E_IDLE});
      tbl.push_back('{8'b1_0_000_1_0_0, E_RD});
      tbl.push_back('{8'b1_0_000_0_1_0, E_RDA});
      tbl.push_back('{I_NOP,            E_IDLE});
      // write: RegEsc stays low on ack
      tbl.push_back('{8'b1_1_111_0_0_0, E_IDLE});
      tbl.push_back('{I_NOP,            E_WR});
      tbl.push_back('{8'b1_0_000_0_1_0, E_WR});
      tbl.push_back('{I_NOP,            E_IDLE});
      // clear sweep with ack every other cycle
      tbl.push_back('{8'b1_1_100_0_0_0, E_IDLE});
      for (int a = 0; a < 4; a++) begin
         tbl.push_back('{8'b1_0_000_0_0_0, eclr(4'(a))});
         tbl.push_back('{8'b1_0_000_0_1_0, eclr(4'(a))});
      end
      tbl.push_back('{I_NOP,            E_IDLE});
      // clear aborted by reset at address 2
      tbl.push_back('{8'b1_1_100_0_0_0, E_IDLE});
      tbl.push_back('{8'b1_0_000_0_1_0, eclr(4'd0)});
      tbl.push_back('{8'b1_0_000_0_1_0, eclr(4'd1)});
      tbl.push_back('{8'b0_0_000_0_0_0, E_RST});
      tbl.push_back('{I_NOP,            E_IDLE});
      // halt, instruction offered for 10 cycles, then Resume together with InstrValid
      tbl.push_back('{8'b1_1_101_0_0_0, E_IDLE});
      for (int i = 0; i < 10; i++)
         tbl.push_back('{(i % 3 == 1) ? 8'b1_1_000_1_1_0 : 8'b1_1_000_0_0_0, E_HALT});
      tbl.push_back('{8'b1_1_000_0_0_1, E_HALT});
      tbl.push_back('{I_NOP,            E_IDLE});
      tbl.push_back('{8'b1_0_000_0_0_1, E_IDLE});
      tbl.push_back('{I_NOP,            E_IDLE});

      foreach (tbl[i]) begin
         apply(tbl[i].in);
         #2;
         check($sformatf("vec%0d", i), outs(), tbl[i].exp);
         step();
      end

      // read left without ack: MemEn holds, no timeout in the default build
      apply(8'b1_1_110_0_0_0);
      step();
      apply(I_NOP);
      for (int i = 0; i < 100; i++) begin
         #2;
         check($sformatf("rd_wait%0d", i), {16'd0, MemEn, MemErr, Busy}, {16'd0, 3'b101});
         step();
      end
      apply(8'b1_0_000_0_1_0);
      #2;
      check("rd_late_ack", outs(), E_RDA);
      step();
      apply(I_NOP);
      #2;
      check("rd_late_idle", outs(), E_IDLE);
      step();

      // clear with MEM_DEPTH=1 (dut1) finishes on its first ack; dut0 keeps sweeping
      apply(8'b1_1_100_0_0_0);
      step();
      apply(8'b1_0_000_0_1_0);
      #2;
      check("d1_clear_first", {13'd0, d1_Clear, d1_MemEn, d1_ClearAddr}, {13'd0, 2'b11, 4'd0});
      step();
      apply(I_NOP);
      #2;
      check("d1_clear_done", {12'd0, d1_InstrReady, d1_Busy, d1_Clear, d1_ClearAddr},
            {12'd0, 3'b100, 4'd0});
      check("d0_clear_cont", outs(), eclr(4'd1));
      apply(8'b1_0_000_0_1_0);
      step();
      step();
      step();
      apply(I_NOP);
      #2;
      check("d0_clear_done", outs(), E_IDLE);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
